cbfp_index_restore: RTL and testbench
=====================================

// Module: cbfp_index_restore
// PURPOSE
//   Inverse of the CBFP normalisation stage. Consumes the 16-lane 12-bit normalised FFT stream plus per-lane
//   re/im shift indices and re-applies each index to put all lanes on one common fixed-point scale.
//   Counts beats into 512-point frames, flags frame boundaries and reports the frame's maximum index.
//   Sits between the CBFP output of an FFT stage and any consumer needing un-normalised data (bit-exact compare, output formatter).
// PARAMETERS
//   NUM_LANE        16  lanes per beat
//   DIN_W           12  signed input sample width
//   IDX_W           5   unsigned shift-index width
//   NORM_BASE       13  left shift undone by the CBFP stage (DIN_W+NORM_BASE == DOUT_W)
//   DOUT_W          25  signed restored sample width
//   BEATS_PER_FRAME 32  beats per frame (512 points / 16 lanes)
// PORTS
//   clk            in   1                   clock, all logic on posedge
//   rstn           in   1                   synchronous reset, ACTIVE-HIGH (name kept for codebase consistency)
//   din_valid      in   1                   input beat valid, no backpressure
//   din_i          in   DIN_W  x NUM_LANE   signed real samples
//   din_q          in   DIN_W  x NUM_LANE   signed imag samples
//   index_re       in   IDX_W  x NUM_LANE   shift index for din_i lanes
//   index_im       in   IDX_W  x NUM_LANE   shift index for din_q lanes
//   valid_out      out  1                   output beat valid
//   dout_i         out  DOUT_W x NUM_LANE   restored real samples
//   dout_q         out  DOUT_W x NUM_LANE   restored imag samples
//   frame_start    out  1                   output beat is beat 0 of a frame
//   frame_end      out  1                   output beat is beat BEATS_PER_FRAME-1
//   frame_max_idx  out  IDX_W               max of all 2*NUM_LANE*BEATS_PER_FRAME indices of the last completed frame
//   idx_clip       out  1                   some lane index in this output beat exceeded DOUT_W-1
// BEHAVIOUR
//   - Reset (rstn=1 at posedge): every output 0, beat counter 0, max accumulator 0, both pipe valids cleared,
//     in-flight beats discarded. First valid beat after reset is beat 0.
//   - Pipeline: fixed 2-cycle latency, valid_out = din_valid delayed 2. Stage1 registers data, clamped index,
//     clip flag, beat number. Stage2 performs shift, drives outputs.
//   - Arithmetic per lane: e = min(idx, DOUT_W-1); dout = (sext_DOUT_W(din) <<< NORM_BASE) >>> e (arithmetic).
//     No rounding, no saturation; e == DOUT_W-1 yields 0 or -1. idx_clip = OR over lanes of (idx > DOUT_W-1).
//   - valid_out low: dout_i/dout_q hold last value; frame_start, frame_end, idx_clip are 0.
//   - Beat counter advances only on din_valid; 0..BEATS_PER_FRAME-1 then wraps to 0; gaps hold it.
//   - frame_start/frame_end are qualified by valid_out and aligned with the beat they describe.
//   - Max accumulator: beat 0 loads that beat's max index (no merge with previous frame); later beats take running max.
//     On the frame_end output beat frame_max_idx updates (includes the last beat), then holds until next frame_end.
//   - Back-to-back frames (beat 31 then beat 0 on consecutive cycles) need no idle cycle.
//   - Reset mid-frame: partial frame abandoned, frame_max_idx returns to 0, no frame_end issued for it.
// TESTING
//   1. Hold rstn=1 -> all outputs 0. Release; lane0 din_i=100, index_re=13 -> 2 cycles later valid_out=1, dout_i[0]=100.
//   2. din_i=-1, idx=0 -> dout_i=-8192. din_q=2047, idx=0 -> dout_q=16769024. din_i=-2048, idx=24 -> -1.
//   3. din_i=5, idx=31 -> dout_i=0, idx_clip=1. din_i=-5, idx=31 -> dout_i=-1, idx_clip=1.
//   4. 32 consecutive beats, lane3 index_re=beat mod 20, all others 0 -> frame_start on out beat 0, frame_end on
//      out beat 31, frame_max_idx=19 from that cycle. Beat 33 -> frame_start=1 again.
//   5. 32 valid beats interleaved with random idle cycles -> frame_end on the 32nd valid_out only, dout held in gaps.
//   6. Assert rstn after beat 10 with 2 beats in flight -> those beats never appear. Next input beat -> frame_start=1, frame_max_idx=0.

Source files
------------

// File: rtl/cbfp_index_restore_if.sv
// Stream bundle for the CBFP index-restore stage: normalised lanes with shift
// indices in, restored lanes with frame markers out.
interface cbfp_index_restore_if #(
  parameter int NUM_LANE = 16,
  parameter int DIN_W    = 12,
  parameter int IDX_W    = 5,
  parameter int DOUT_W   = 25
);
  logic                               din_valid;
  logic [NUM_LANE-1:0][DIN_W-1:0]     din_i;
  logic [NUM_LANE-1:0][DIN_W-1:0]     din_q;
  logic [NUM_LANE-1:0][IDX_W-1:0]     index_re;
  logic [NUM_LANE-1:0][IDX_W-1:0]     index_im;
  logic                               valid_out;
  logic [NUM_LANE-1:0][DOUT_W-1:0]    dout_i;
  logic [NUM_LANE-1:0][DOUT_W-1:0]    dout_q;
  logic                               frame_start;
  logic                               frame_end;
  logic [IDX_W-1:0]                   frame_max_idx;
  logic                               idx_clip;

  modport master (
    output din_valid, din_i, din_q, index_re, index_im,
    input  valid_out, dout_i, dout_q, frame_start, frame_end, frame_max_idx, idx_clip
  );

  modport slave (
    input  din_valid, din_i, din_q, index_re, index_im,
    output valid_out, dout_i, dout_q, frame_start, frame_end, frame_max_idx, idx_clip
  );
endinterface

// File: rtl/cbfp_index_restore.sv
// Undoes CBFP block normalisation: each lane is rescaled by its own shift index
// onto a common fixed-point scale, with 512-point frame tracking and max-index report.
module cbfp_index_restore #(
  parameter int NUM_LANE        = 16,
  parameter int DIN_W           = 12,
  parameter int IDX_W           = 5,
  parameter int NORM_BASE       = 13,
  parameter int DOUT_W          = 25,
  parameter int BEATS_PER_FRAME = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  cbfp_index_restore_if.slave  bus
);

  localparam int BEAT_W = $clog2(BEATS_PER_FRAME);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [IDX_W-1:0]  E_CLAMP   = IDX_W'(DOUT_W - 1);

  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
    if (idx > E_CLAMP) return E_CLAMP;
    else               return idx;
  endfunction

  // Input sits at the top of the output word, so an arithmetic right shift by e re-scales it.
  function automatic logic [DOUT_W-1:0] restore(input logic [DIN_W-1:0] d,
                                                input logic [IDX_W-1:0] e);
    logic signed [DOUT_W-1:0] w;
    w = $signed({d, {NORM_BASE{1'b0}}});
    return w >>> e;
  endfunction

  logic                            r_s1_valid;
  logic [NUM_LANE-1:0][DIN_W-1:0]  r_s1_di;
  logic [NUM_LANE-1:0][DIN_W-1:0]  r_s1_dq;
  logic [NUM_LANE-1:0][IDX_W-1:0]  r_s1_ei;
  logic [NUM_LANE-1:0][IDX_W-1:0]  r_s1_eq;
  logic                            r_s1_clip;
  logic [IDX_W-1:0]                r_s1_max;
  logic [BEAT_W-1:0]               r_s1_beat;
  logic [BEAT_W-1:0]               r_beat;

  logic                            r_valid_out;
  logic [NUM_LANE-1:0][DOUT_W-1:0] r_dout_i;
  logic [NUM_LANE-1:0][DOUT_W-1:0] r_dout_q;
  logic                            r_frame_start;
  logic                            r_frame_end;
  logic                            r_idx_clip;
  logic [IDX_W-1:0]                r_acc;
  logic [IDX_W-1:0]                r_frame_max;

  logic [NUM_LANE-1:0][IDX_W-1:0]  w_ei;
  logic [NUM_LANE-1:0][IDX_W-1:0]  w_eq;
  logic                            w_clip;
  logic [IDX_W-1:0]                w_beat_max;
  logic [NUM_LANE-1:0][DOUT_W-1:0] w_shift_i;
  logic [NUM_LANE-1:0][DOUT_W-1:0] w_shift_q;
  logic [IDX_W-1:0]                w_acc_next;

  // Beat max uses raw indices; only the shift amount is clamped.
  always_comb begin
    w_ei       = '0;
    w_eq       = '0;
    w_clip     = 1'b0;
    w_beat_max = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      w_ei[l] = clamp_idx(bus.index_re[l]);
      w_eq[l] = clamp_idx(bus.index_im[l]);
      if ((bus.index_re[l] > E_CLAMP) || (bus.index_im[l] > E_CLAMP)) w_clip = 1'b1;
      else                                                              w_clip = w_clip;
      if (bus.index_re[l] > w_beat_max) w_beat_max = bus.index_re[l];
      else                              w_beat_max = w_beat_max;
      if (bus.index_im[l] > w_beat_max) w_beat_max = bus.index_im[l];
      else                              w_beat_max = w_beat_max;
    end
  end

  always_comb begin
    w_shift_i  = '0;
    w_shift_q  = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      w_shift_i[l] = restore(r_s1_di[l], r_s1_ei[l]);
      w_shift_q[l] = restore(r_s1_dq[l], r_s1_eq[l]);
    end
    // Beat 0 starts a fresh accumulation with no carry-over from the previous frame.
    if (r_s1_beat == '0)          w_acc_next = r_s1_max;
    else if (r_s1_max > r_acc)    w_acc_next = r_s1_max;
    else                          w_acc_next = r_acc;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_di    <= '0;
      r_s1_dq    <= '0;
      r_s1_ei    <= '0;
      r_s1_eq    <= '0;
      r_s1_clip  <= 1'b0;
      r_s1_max   <= '0;
      r_s1_beat  <= '0;
      r_beat     <= '0;
    end else begin
      r_s1_valid <= bus.din_valid;
      if (bus.din_valid) begin
        r_s1_di   <= bus.din_i;
        r_s1_dq   <= bus.din_q;
        r_s1_ei   <= w_ei;
        r_s1_eq   <= w_eq;
        r_s1_clip <= w_clip;
        r_s1_max  <= w_beat_max;
        r_s1_beat <= r_beat;
        if (r_beat == LAST_BEAT) r_beat <= '0;
        else                     r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_valid_out   <= 1'b0;
      r_dout_i      <= '0;
      r_dout_q      <= '0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_idx_clip    <= 1'b0;
      r_acc         <= '0;
      r_frame_max   <= '0;
    end else begin
      r_valid_out   <= r_s1_valid;
      r_frame_start <= r_s1_valid && (r_s1_beat == '0);
      r_frame_end   <= r_s1_valid && (r_s1_beat == LAST_BEAT);
      r_idx_clip    <= r_s1_valid && r_s1_clip;
      if (r_s1_valid) begin
        r_dout_i <= w_shift_i;
        r_dout_q <= w_shift_q;
        r_acc    <= w_acc_next;
        if (r_s1_beat == LAST_BEAT) r_frame_max <= w_acc_next;
      end
    end
  end

  assign bus.valid_out     = r_valid_out;
  assign bus.dout_i        = r_dout_i;
  assign bus.dout_q        = r_dout_q;
  assign bus.frame_start   = r_frame_start;
  assign bus.frame_end     = r_frame_end;
  assign bus.idx_clip      = r_idx_clip;
  assign bus.frame_max_idx = r_frame_max;

endmodule

// File: tb/tb_cbfp_index_restore.sv
// Directed bench for cbfp_index_restore: expected beats are queued when driven
// and compared in order as valid_out presents them.
module tb_cbfp_index_restore;
  localparam int NL  = 16;
  localparam int DW  = 12;
  localparam int IW  = 5;
  localparam int OW  = 25;
  localparam int NB  = 13;
  localparam int BPF = 32;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  cbfp_index_restore_if bus();
  cbfp_index_restore dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*OW-1:0] di;
    logic [NL*OW-1:0] dq;
    logic             fs;
    logic             fe;
    logic             clip;
    logic [IW-1:0]    fmax;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;
  int stall  = 0;
  int m_beat = 0;
  logic [IW-1:0] m_acc  = '0;
  logic [IW-1:0] m_fmax = '0;
  logic [NL*OW-1:0] last_i = '0;
  logic [NL*OW-1:0] last_q = '0;

  logic [NL-1:0][DW-1:0] tdi, tdq;
  logic [NL-1:0][IW-1:0] tire, tiim;

  task automatic chk(input string tag, input logic [NL*OW-1:0] obs, input logic [NL*OW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_restore(input logic [DW-1:0] d, input logic [IW-1:0] idx);
    longint v;
    int e;
    v = longint'($signed(d)) * (longint'(1) << NB);
    e = (int'(idx) > OW - 1) ? OW - 1 : int'(idx);
    v = v >>> e;
    return v[OW-1:0];
  endfunction

  task automatic check_out();
    exp_t e;
    if (rstn) begin
      chk("rst_valid", NL*OW'(bus.valid_out), '0);
      chk("rst_dout_i", bus.dout_i, '0);
      chk("rst_dout_q", bus.dout_q, '0);
      chk("rst_flags", NL*OW'({bus.frame_start, bus.frame_end, bus.idx_clip}), '0);
      chk("rst_fmax", NL*OW'(bus.frame_max_idx), '0);
      last_i = '0;
      last_q = '0;
    end else if (bus.valid_out) begin
      stall = 0;
      if (q.size() == 0) begin
        chk("unexpected_out", NL*OW'(bus.valid_out), '0);
      end else begin
        e = q.pop_front();
        chk("dout_i", bus.dout_i, e.di);
        chk("dout_q", bus.dout_q, e.dq);
        chk("frame_start", NL*OW'(bus.frame_start), NL*OW'(e.fs));
        chk("frame_end", NL*OW'(bus.frame_end), NL*OW'(e.fe));
        chk("idx_clip", NL*OW'(bus.idx_clip), NL*OW'(e.clip));
        chk("frame_max_idx", NL*OW'(bus.frame_max_idx), NL*OW'(e.fmax));
      end
      last_i = bus.dout_i;
      last_q = bus.dout_q;
    end else begin
      chk("hold_i", bus.dout_i, last_i);
      chk("hold_q", bus.dout_q, last_q);
      chk("idle_flags", NL*OW'({bus.frame_start, bus.frame_end, bus.idx_clip}), '0);
      if (q.size() > 0) begin
        stall++;
        if (stall > 3) begin
          chk("out_timeout", NL*OW'(stall), '0);
          q.delete();
          stall = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic send();
    exp_t e;
    logic [IW-1:0] m;
    m = '0;
    e.clip = 1'b0;
    for (int l = 0; l < NL; l++) begin
      e.di[l*OW +: OW] = model_restore(tdi[l], tire[l]);
      e.dq[l*OW +: OW] = model_restore(tdq[l], tiim[l]);
      if (tire[l] > m) m = tire[l];
      if (tiim[l] > m) m = tiim[l];
      if (tire[l] > 5'd24 || tiim[l] > 5'd24) e.clip = 1'b1;
    end
    e.fs = (m_beat == 0);
    e.fe = (m_beat == BPF - 1);
    if (m_beat == 0) m_acc = m;
    else if (m > m_acc) m_acc = m;
    if (e.fe) m_fmax = m_acc;
    e.fmax = m_fmax;
    m_beat = (m_beat + 1) % BPF;
    q.push_back(e);
    bus.din_valid = 1'b1;
    bus.din_i = tdi;
    bus.din_q = tdq;
    bus.index_re = tire;
    bus.index_im = tiim;
    tick();
  endtask

  task automatic idle();
    bus.din_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      bus.din_i[l]    = DW'($urandom);
      bus.din_q[l]    = DW'($urandom);
      bus.index_re[l] = IW'($urandom);
      bus.index_im[l] = IW'($urandom);
    end
    tick();
  endtask

  task automatic clear_beat();
    tdi = '0; tdq = '0; tire = '0; tiim = '0;
  endtask

  task automatic rand_beat();
    for (int l = 0; l < NL; l++) begin
      tdi[l]  = DW'($urandom);
      tdq[l]  = DW'($urandom);
      tire[l] = IW'($urandom_range(0, 31));
      tiim[l] = IW'($urandom_range(0, 31));
    end
  endtask

  task automatic apply_reset(input int n, input logic v);
    rstn = 1'b1;
    bus.din_valid = v;
    q.delete();
    stall  = 0;
    m_beat = 0;
    m_acc  = '0;
    m_fmax = '0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) idle();
    chk("drain_empty", NL*OW'(q.size()), '0);
  endtask

  initial begin
    clear_beat();
    bus.din_valid = 1'b0;
    bus.din_i = '0; bus.din_q = '0; bus.index_re = '0; bus.index_im = '0;

    // Reset, then a single beat: two-cycle latency, index 13 cancels the base shift.
    apply_reset(3, 1'b1);
    clear_beat();
    tdi[0] = 12'd100; tire[0] = 5'd13;
    send();
    chk("t1_latency_lo", NL*OW'(bus.valid_out), '0);
    idle();
    chk("t1_latency_hi", NL*OW'(bus.valid_out), NL*OW'(1'b1));
    chk("t1_lane0", NL*OW'(bus.dout_i[0]), NL*OW'(25'd100));

    // Sign extension and the extreme shift amounts.
    rand_beat();
    tdi[0] = 12'hFFF;      tire[0] = 5'd0;
    tdq[0] = 12'd2047;     tiim[0] = 5'd0;
    tdi[1] = 12'h800;      tire[1] = 5'd24;
    send();
    idle();
    chk("t2_neg1_idx0", NL*OW'(bus.dout_i[0]), NL*OW'(25'h1FFE000));
    chk("t2_max_idx0", NL*OW'(bus.dout_q[0]), NL*OW'(25'd16769024));
    chk("t2_min_idx24", NL*OW'(bus.dout_i[1]), NL*OW'(25'h1FFFFFF));

    clear_beat();
    tdi[0] = 12'd5;  tire[0] = 5'd31;
    tdi[1] = 12'hFFB; tire[1] = 5'd31;
    send();
    idle();
    chk("t3_pos_clip", NL*OW'(bus.dout_i[0]), '0);
    chk("t3_neg_clip", NL*OW'(bus.dout_i[1]), NL*OW'(25'h1FFFFFF));
    chk("t3_clip_flag", NL*OW'(bus.idx_clip), NL*OW'(1'b1));
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      send();
    end
    drain();

    // Full frame back-to-back, lane3 real index ramps modulo 20.
    apply_reset(2, 1'b0);
    for (int b = 0; b < 33; b++) begin
      rand_beat();
      tire = '0; tiim = '0;
      tire[3] = IW'(b % 20);
      send();
    end
    chk("t4_frame_end", NL*OW'(bus.frame_end), NL*OW'(1'b1));
    chk("t4_frame_max", NL*OW'(bus.frame_max_idx), NL*OW'(5'd19));
    idle();
    chk("t4_frame_start_again", NL*OW'(bus.frame_start), NL*OW'(1'b1));

    // Rest of the second frame with idle gaps between beats.
    for (int b = 0; b < 31; b++) begin
      rand_beat();
      send();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
    end
    drain();

    // Reset mid-frame with two beats in flight.
    for (int b = 0; b < 11; b++) begin
      rand_beat();
      send();
    end
    rand_beat();
    bus.din_i = tdi; bus.din_q = tdq; bus.index_re = tire; bus.index_im = tiim;
    apply_reset(1, 1'b1);
    idle();
    idle();
    rand_beat();
    send();
    idle();
    chk("t6_frame_start", NL*OW'(bus.frame_start), NL*OW'(1'b1));
    chk("t6_frame_max", NL*OW'(bus.frame_max_idx), '0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
